// File: rtl/crc_pkg.sv
// Shared types, CRC-32 / CRC-16/CCITT-FALSE parameter sets and the single-byte CRC step.
// Latency: n/a (types and a combinational function only).
// Backpressure: n/a.
package crc_pkg;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HOLD = 1'b1
    } crc_state_t;

    // CRC-32 (IEEE 802.3, reflected)
    localparam int          CRC32_W       = 32;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_XOR_OUT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;
    localparam bit          CRC32_REFLECT = 1'b1;

    // CRC-16/CCITT-FALSE (MSB-first)
    localparam int          CRC16_W       = 16;
    localparam logic [31:0] CRC16_POLY    = 32'h0000_1021;
    localparam logic [31:0] CRC16_INIT    = 32'h0000_FFFF;
    localparam logic [31:0] CRC16_XOR_OUT = 32'h0000_0000;
    localparam logic [31:0] CRC16_RESIDUE = 32'h0000_0000;
    localparam bit          CRC16_REFLECT = 1'b0;

    // One byte through the shift/XOR register. The caller aligns narrow CRCs:
    // right-aligned (low bits) when reflected, left-aligned (top bits) otherwise,
    // with the polynomial aligned the same way. This keeps one 32-bit datapath
    // valid for every width from 8 to 32.
    function automatic logic [31:0] crc_step8(input logic [31:0] crc,
                                              input logic [7:0]  data_byte,
                                              input logic [31:0] poly,
                                              input bit          reflect);
        logic [31:0] c;
        c = crc;
        if (reflect) begin
            c[7:0] = c[7:0] ^ data_byte;
            for (int i = 0; i < 8; i++) begin
                c = c[0] ? ((c >> 1) ^ poly) : (c >> 1);
            end
        end else begin
            c[31:24] = c[31:24] ^ data_byte;
            for (int i = 0; i < 8; i++) begin
                c = c[31] ? ((c << 1) ^ poly) : (c << 1);
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc_update.sv
// Combinational CRC update of up to DATA_BYTES bytes, byte 0 first, gated by a keep mask.
// Latency: zero (pure combinational, fully unrolled 8*DATA_BYTES steps).
// Backpressure: none; stateless.
module crc_update
    import crc_pkg::*;
#(
    parameter int          CRC_W      = 32,
    parameter logic [31:0] POLY       = CRC32_POLY,
    parameter bit          REFLECT    = CRC32_REFLECT,
    parameter int          DATA_BYTES = 4
) (
    input  logic [CRC_W-1:0]        crc_i,
    input  logic [8*DATA_BYTES-1:0] data_i,
    input  logic [DATA_BYTES-1:0]   keep_i,
    output logic [CRC_W-1:0]        crc_o
);

    localparam int               SH     = 32 - CRC_W;
    localparam logic [CRC_W-1:0] POLY_T = POLY[CRC_W-1:0];
    localparam logic [31:0]      POLY_A = REFLECT ? 32'(POLY_T) : (32'(POLY_T) << SH);

    logic [31:0] acc;

    // Align the register, run each kept byte in order, then undo the alignment.
    always_comb begin
        acc = REFLECT ? 32'(crc_i) : (32'(crc_i) << SH);
        for (int b = 0; b < DATA_BYTES; b++) begin
            if (keep_i[b]) begin
                acc = crc_step8(acc, data_i[8*b +: 8], POLY_A, REFLECT);
            end
        end
        crc_o = REFLECT ? acc[CRC_W-1:0] : CRC_W'(acc >> SH);
    end

endmodule

// File: rtl/crc_stream.sv
// Streaming CRC engine: 1..DATA_BYTES bytes per beat, one registered result per frame.
// Latency: crc_valid rises on the edge after the s_last beat is accepted (1 cycle).
// Backpressure: s_ready drops while a result is held; held until crc_ready, clear aborts.
module crc_stream
    import crc_pkg::*;
#(
    parameter int          CRC_W      = 32,
    parameter logic [31:0] POLY       = CRC32_POLY,
    parameter logic [31:0] INIT       = CRC32_INIT,
    parameter logic [31:0] XOR_OUT    = CRC32_XOR_OUT,
    parameter logic [31:0] RESIDUE    = CRC32_RESIDUE,
    parameter bit          REFLECT    = CRC32_REFLECT,
    parameter int          DATA_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clear,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [8*DATA_BYTES-1:0] s_data,
    input  logic [DATA_BYTES-1:0]   s_keep,
    input  logic                    s_last,
    output logic                    crc_valid,
    input  logic                    crc_ready,
    output logic [CRC_W-1:0]        crc_out,
    output logic                    crc_match,
    output logic [15:0]             frame_len
);

    localparam logic [CRC_W-1:0] INIT_T = INIT[CRC_W-1:0];
    localparam logic [CRC_W-1:0] XOR_T  = XOR_OUT[CRC_W-1:0];
    localparam logic [CRC_W-1:0] RES_T  = RESIDUE[CRC_W-1:0];

    crc_state_t       state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d, crc_upd;
    logic [CRC_W-1:0] out_q, out_d;
    logic             match_q, match_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [15:0]      len_q, len_d;
    logic [15:0]      nbytes;
    logic [16:0]      cnt_sum;
    logic [15:0]      cnt_nxt;

    crc_update #(
        .CRC_W      (CRC_W),
        .POLY       (POLY),
        .REFLECT    (REFLECT),
        .DATA_BYTES (DATA_BYTES)
    ) u_update (
        .crc_i  (crc_q),
        .data_i (s_data),
        .keep_i (s_keep),
        .crc_o  (crc_upd)
    );

    // Kept-byte count of the current beat (keep is contiguous, so a popcount).
    always_comb begin
        nbytes = '0;
        for (int b = 0; b < DATA_BYTES; b++) begin
            nbytes = nbytes + 16'(s_keep[b]);
        end
    end

    // Frame length accumulates and sticks at all-ones instead of wrapping.
    assign cnt_sum = {1'b0, cnt_q} + {1'b0, nbytes};
    assign cnt_nxt = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

    // Next state, CRC register, counter and result capture; clear wins over everything.
    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        match_d = match_q;
        len_d   = len_q;
        if (clear) begin
            state_d = RUN;
            crc_d   = INIT_T;
            cnt_d   = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (s_valid) begin
                        if (s_last) begin
                            out_d   = crc_upd ^ XOR_T;
                            match_d = (crc_upd == RES_T);
                            len_d   = cnt_nxt;
                            crc_d   = INIT_T;
                            cnt_d   = '0;
                            state_d = HOLD;
                        end else begin
                            crc_d = crc_upd;
                            cnt_d = cnt_nxt;
                        end
                    end
                end
                HOLD: begin
                    if (crc_ready) begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: running CRC, byte count and the held result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_q   <= INIT_T;
            cnt_q   <= '0;
            out_q   <= '0;
            match_q <= 1'b0;
            len_q   <= '0;
        end else begin
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            match_q <= match_d;
            len_q   <= len_d;
        end
    end

    assign s_ready   = (state_q == RUN);
    assign crc_valid = (state_q == HOLD);
    assign crc_out   = out_q;
    assign crc_match = match_q;
    assign frame_len = len_q;

endmodule

// File: tb/tb_crc_stream.sv
// Self-checking bench: CRC-32 x4-byte instance and CRC-16/CCITT-FALSE x1-byte instance,
// randomized frames checked against a bit-serial reference model, plus fixed vectors.
// Covers backpressure, clear, async reset, empty frames and length saturation.
module tb_crc_stream;

    localparam logic [31:0] P32 = 32'hEDB8_8320;
    localparam logic [31:0] I32 = 32'hFFFF_FFFF;
    localparam logic [31:0] X32 = 32'hFFFF_FFFF;
    localparam logic [31:0] R32 = 32'hDEBB_20E3;
    localparam logic [31:0] P16 = 32'h0000_1021;
    localparam logic [31:0] I16 = 32'h0000_FFFF;

    logic clk = 1'b0;
    logic reset_n;

    logic        a_clear, a_valid, a_last, a_crc_ready;
    logic [31:0] a_data;
    logic [3:0]  a_keep;
    logic        a_s_ready, a_crc_valid, a_match;
    logic [31:0] a_crc_out;
    logic [15:0] a_len;

    logic        b_clear, b_valid, b_last, b_crc_ready;
    logic [7:0]  b_data;
    logic [0:0]  b_keep;
    logic        b_s_ready, b_crc_valid, b_match;
    logic [15:0] b_crc_out;
    logic [15:0] b_len;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] fq[$];

    always #5 clk = ~clk;

    crc_stream u_dut32 (
        .clk(clk), .reset_n(reset_n), .clear(a_clear),
        .s_valid(a_valid), .s_ready(a_s_ready), .s_data(a_data), .s_keep(a_keep), .s_last(a_last),
        .crc_valid(a_crc_valid), .crc_ready(a_crc_ready), .crc_out(a_crc_out),
        .crc_match(a_match), .frame_len(a_len)
    );

    crc_stream #(
        .CRC_W(16), .POLY(P16), .INIT(I16), .XOR_OUT(32'h0), .RESIDUE(32'h0),
        .REFLECT(1'b0), .DATA_BYTES(1)
    ) u_dut16 (
        .clk(clk), .reset_n(reset_n), .clear(b_clear),
        .s_valid(b_valid), .s_ready(b_s_ready), .s_data(b_data), .s_keep(b_keep), .s_last(b_last),
        .crc_valid(b_crc_valid), .crc_ready(b_crc_ready), .crc_out(b_crc_out),
        .crc_match(b_match), .frame_len(b_len)
    );

    // Byte enables must always be contiguous from bit 0.
    always @(posedge clk) begin
        if (a_valid) assert ((a_keep & (a_keep + 4'd1)) == 4'd0) else $error("a_keep not contiguous");
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: message bits fed one at a time in line order (LSB-first when reflected).
    function automatic logic [31:0] ref_byte(input logic [31:0] crc, input logic [7:0] b,
                                             input int w, input bit refl, input logic [31:0] poly);
        logic [31:0] mask, c, p;
        logic fb;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        c = crc & mask;
        p = poly & mask;
        for (int i = 0; i < 8; i++) begin
            if (refl) begin
                fb = c[0] ^ b[i];
                c  = c >> 1;
            end else begin
                fb = c[w-1] ^ b[7-i];
                c  = (c << 1) & mask;
            end
            if (fb) c = c ^ p;
        end
        return c;
    endfunction

    function automatic logic [31:0] ref_frame(input int w, input bit refl,
                                              input logic [31:0] poly, input logic [31:0] init);
        logic [31:0] c;
        c = init;
        foreach (fq[i]) c = ref_byte(c, fq[i], w, refl, poly);
        return c;
    endfunction

    function automatic logic [15:0] ref_len();
        return (fq.size() > 65535) ? 16'hFFFF : 16'(fq.size());
    endfunction

    task automatic load_str(input string s);
        fq.delete();
        for (int i = 0; i < s.len(); i++) fq.push_back(s[i]);
    endtask

    task automatic a_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        a_valid = 1'b1; a_data = d; a_keep = k; a_last = l;
        @(posedge clk); #1;
        a_valid = 1'b0; a_last = 1'b0; a_keep = 4'h0; a_data = $urandom;
    endtask

    task automatic a_send_fq();
        int idx, n, rem;
        logic [31:0] d;
        bit last;
        idx = 0;
        while (1) begin
            if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
            if ($urandom_range(0, 5) == 0 && idx < fq.size()) a_beat($urandom, 4'h0, 1'b0);
            rem  = fq.size() - idx;
            n    = (rem == 0) ? 0 : int'($urandom_range(1, (rem < 4) ? rem : 4));
            last = (idx + n == fq.size());
            d    = $urandom;
            for (int b = 0; b < n; b++) d[8*b +: 8] = fq[idx+b];
            if (last) check_eq("a_valid_pre", 32'(a_crc_valid), 32'd0);
            a_beat(d, 4'((1 << n) - 1), last);
            idx += n;
            if (last) break;
        end
    endtask

    task automatic a_expect(input logic [31:0] e_out, input logic e_match,
                            input logic [15:0] e_len, input int hold);
        check_eq("a_valid", 32'(a_crc_valid), 32'd1);
        check_eq("a_s_ready_hold", 32'(a_s_ready), 32'd0);
        check_eq("a_crc_out", a_crc_out, e_out);
        check_eq("a_match", 32'(a_match), 32'(e_match));
        check_eq("a_len", 32'(a_len), 32'(e_len));
        repeat (hold) begin
            @(posedge clk); #1;
            check_eq("a_out_stable", a_crc_out, e_out);
            check_eq("a_s_ready_bp", 32'(a_s_ready), 32'd0);
        end
        a_crc_ready = 1'b1;
        @(posedge clk); #1;
        a_crc_ready = 1'b0;
        check_eq("a_valid_done", 32'(a_crc_valid), 32'd0);
        check_eq("a_s_ready_done", 32'(a_s_ready), 32'd1);
    endtask

    task automatic a_model_expect(input int hold);
        logic [31:0] r;
        r = ref_frame(32, 1'b1, P32, I32);
        a_expect(r ^ X32, r == R32, ref_len(), hold);
    endtask

    task automatic b_beat(input logic [7:0] d, input logic k, input logic l);
        b_valid = 1'b1; b_data = d; b_keep = k; b_last = l;
        @(posedge clk); #1;
        b_valid = 1'b0; b_last = 1'b0; b_keep = 1'b0; b_data = 8'($urandom);
    endtask

    task automatic b_send_fq();
        if (fq.size() == 0) begin
            check_eq("b_valid_pre", 32'(b_crc_valid), 32'd0);
            b_beat(8'($urandom), 1'b0, 1'b1);
        end else begin
            for (int i = 0; i < fq.size(); i++) begin
                if ($urandom_range(0, 4) == 0) b_beat(8'($urandom), 1'b0, 1'b0);
                if (i == fq.size() - 1) check_eq("b_valid_pre", 32'(b_crc_valid), 32'd0);
                b_beat(fq[i], 1'b1, i == fq.size() - 1);
            end
        end
    endtask

    task automatic b_expect(input logic [15:0] e_out, input logic e_match, input logic [15:0] e_len);
        check_eq("b_valid", 32'(b_crc_valid), 32'd1);
        check_eq("b_s_ready_hold", 32'(b_s_ready), 32'd0);
        check_eq("b_crc_out", 32'(b_crc_out), 32'(e_out));
        check_eq("b_match", 32'(b_match), 32'(e_match));
        check_eq("b_len", 32'(b_len), 32'(e_len));
        b_crc_ready = 1'b1;
        @(posedge clk); #1;
        b_crc_ready = 1'b0;
        check_eq("b_valid_done", 32'(b_crc_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        int nb;
        reset_n = 1'b0;
        a_clear = 0; a_valid = 0; a_last = 0; a_crc_ready = 0; a_data = '0; a_keep = '0;
        b_clear = 0; b_valid = 0; b_last = 0; b_crc_ready = 0; b_data = '0; b_keep = '0;
        #12 reset_n = 1'b1;
        @(posedge clk); #1;

        // Reset values
        check_eq("rst_a_s_ready", 32'(a_s_ready), 32'd1);
        check_eq("rst_a_valid", 32'(a_crc_valid), 32'd0);
        check_eq("rst_a_out", a_crc_out, 32'd0);
        check_eq("rst_a_match", 32'(a_match), 32'd0);
        check_eq("rst_a_len", 32'(a_len), 32'd0);
        check_eq("rst_b_out", 32'(b_crc_out), 32'd0);

        // "123456789" as the three fixed beats
        a_beat(32'h3433_3231, 4'hF, 1'b0);
        a_beat(32'h3837_3635, 4'hF, 1'b0);
        check_eq("a_valid_pre", 32'(a_crc_valid), 32'd0);
        a_beat(32'h0000_0039, 4'h1, 1'b1);
        a_expect(32'hCBF4_3926, 1'b0, 16'd9, 0);

        // Appended CRC gives the residue; hold crc_ready low for 5 cycles
        load_str("123456789");
        fq.push_back(8'h26); fq.push_back(8'h39); fq.push_back(8'hF4); fq.push_back(8'hCB);
        a_send_fq();
        a_expect(32'h2144_DF1C, 1'b1, 16'd13, 5);

        // Empty frame
        check_eq("a_valid_pre", 32'(a_crc_valid), 32'd0);
        a_beat(32'hDEAD_BEEF, 4'h0, 1'b1);
        a_expect(32'h0000_0000, 1'b0, 16'd0, 0);

        // crc_ready tied high: exactly one cycle in HOLD
        a_crc_ready = 1'b1;
        load_str("abc");
        a_send_fq();
        check_eq("a_hold1_valid", 32'(a_crc_valid), 32'd1);
        r = ref_frame(32, 1'b1, P32, I32);
        check_eq("a_hold1_out", a_crc_out, r ^ X32);
        @(posedge clk); #1;
        check_eq("a_hold1_done", 32'(a_crc_valid), 32'd0);
        check_eq("a_hold1_ready", 32'(a_s_ready), 32'd1);
        a_crc_ready = 1'b0;

        // clear mid-frame, with a last beat presented in the same cycle
        a_beat($urandom, 4'hF, 1'b0);
        a_beat($urandom, 4'h7, 1'b0);
        check_eq("a_ready_mid", 32'(a_s_ready), 32'd1);
        a_clear = 1'b1;
        a_beat($urandom, 4'hF, 1'b1);
        a_clear = 1'b0;
        check_eq("a_clr_valid", 32'(a_crc_valid), 32'd0);
        load_str("123456789");
        a_send_fq();
        a_expect(32'hCBF4_3926, 1'b0, 16'd9, 1);

        // clear while holding a result
        load_str("xyz");
        a_send_fq();
        check_eq("a_clrh_valid0", 32'(a_crc_valid), 32'd1);
        a_clear = 1'b1;
        @(posedge clk); #1;
        a_clear = 1'b0;
        check_eq("a_clrh_valid", 32'(a_crc_valid), 32'd0);
        check_eq("a_clrh_ready", 32'(a_s_ready), 32'd1);

        // Async reset while a result is held
        load_str("123456789");
        a_send_fq();
        check_eq("a_pre_rst_out", a_crc_out, 32'hCBF4_3926);
        reset_n = 1'b0;
        #1;
        check_eq("arst_valid", 32'(a_crc_valid), 32'd0);
        check_eq("arst_ready", 32'(a_s_ready), 32'd1);
        check_eq("arst_out", a_crc_out, 32'd0);
        check_eq("arst_len", 32'(a_len), 32'd0);
        #3 reset_n = 1'b1;
        @(posedge clk); #1;

        // Async reset mid-frame, then a clean frame from INIT
        a_beat($urandom, 4'hF, 1'b0);
        a_beat($urandom, 4'h3, 1'b0);
        #2 reset_n = 1'b0;
        #4 reset_n = 1'b1;
        @(posedge clk); #1;
        load_str("123456789");
        a_send_fq();
        a_expect(32'hCBF4_3926, 1'b0, 16'd9, 0);

        // Random frames against the model
        for (int f = 0; f < 25; f++) begin
            fq.delete();
            nb = $urandom_range(0, 20);
            for (int i = 0; i < nb; i++) fq.push_back(8'($urandom));
            a_send_fq();
            a_model_expect($urandom_range(0, 3));
        end

        // Frame length saturation (65540 bytes)
        fq.delete();
        for (int i = 0; i < 65540; i++) fq.push_back(8'($urandom));
        for (int i = 0; i < 65540 / 4; i++) begin
            if (i == 65540 / 4 - 1) check_eq("a_valid_pre", 32'(a_crc_valid), 32'd0);
            a_beat({fq[4*i+3], fq[4*i+2], fq[4*i+1], fq[4*i]}, 4'hF, i == 65540 / 4 - 1);
        end
        a_model_expect(0);
        check_eq("a_len_sat", 32'(a_len), 32'h0000_FFFF);

        // CRC-16/CCITT-FALSE, MSB-first, one byte per beat
        load_str("123456789");
        b_send_fq();
        b_expect(16'h29B1, 1'b0, 16'd9);
        fq.push_back(8'h29); fq.push_back(8'hB1);
        b_send_fq();
        b_expect(16'h0000, 1'b1, 16'd11);
        for (int f = 0; f < 10; f++) begin
            fq.delete();
            nb = $urandom_range(0, 12);
            for (int i = 0; i < nb; i++) fq.push_back(8'($urandom));
            b_send_fq();
            r = ref_frame(16, 1'b0, P16, I16);
            b_expect(r[15:0], r == 32'd0, ref_len());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/crc_stream.md
# crc_stream

Parametrised streaming CRC engine that replaces the fixed byte-serial CRC-32 unit. It accepts 1–4 bytes per cycle over a valid/ready stream with byte enables and frame delimiting. It produces one registered CRC result per frame, with a result handshake, a residue-match flag and a frame byte count. It sits between media/ROM loaders or SD sector paths and the checksum-comparison logic.

## Interface
Parameters:
- CRC_W, 32, CRC width in bits (8..32).
- POLY, 32'hEDB88320, generator polynomial, CRC_W bits, written in the bit order selected by REFLECT.
- INIT, 32'hFFFFFFFF, register value at reset, after `clear`, and after each completed frame.
- XOR_OUT, 32'hFFFFFFFF, XORed into the final register value to form `crc_out`.
- RESIDUE, 32'hDEBB20E3, final register value before XOR_OUT that signals a good frame whose own CRC was appended.
- REFLECT, 1, 1 = LSB-first (shift right); 0 = MSB-first (byte placed in the top 8 bits, shift left).
- DATA_BYTES, 4, bytes per beat (1..4); byte 0 = `s_data[7:0]`, processed first.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous abort: discards the current frame and any pending result.
- s_valid  in  1  beat valid.
- s_ready  out  1  beat accepted when `s_valid && s_ready`.
- s_data  in  8*DATA_BYTES  beat data.
- s_keep  in  DATA_BYTES  byte enables; contiguous from bit 0.
- s_last  in  1  final beat of the frame.
- crc_valid  out  1  result available.
- crc_ready  in  1  result consumed when `crc_valid && crc_ready`.
- crc_out  out  CRC_W  final CRC, `reg ^ XOR_OUT`.
- crc_match  out  1  final register (before XOR_OUT) == RESIDUE.
- frame_len  out  16  bytes in the frame, saturating at 16'hFFFF.

## Operation
- State machine with two states, RUN and HOLD. Reset state is RUN.
- RUN:
  - `s_ready` = 1.
  - On an accepted beat, the first popcount(`s_keep`) bytes update the CRC register in order.
  - Each byte is one 8-step shift/XOR in the mode set by REFLECT.
  - The byte count accumulates with saturation.
- Accepted beat with `s_last`:
  - Register `crc_out`, `crc_match` and `frame_len` from the post-beat values.
  - Load the CRC register with INIT and zero the byte count.
  - Go to HOLD.
- HOLD:
  - `s_ready` = 0 and `crc_valid` = 1.
  - Outputs stay stable until `crc_ready`, then return to RUN.
- `s_keep` = 0 on a non-last beat is a no-op. On a last beat it finalises without new bytes.
- Non-contiguous `s_keep` is illegal. The bench asserts it never occurs; RTL behaviour for it is undefined.
- `clear` takes priority over every other event in the same cycle:
  - CRC register = INIT, byte count = 0, state = RUN.
  - `crc_valid` drops, and any beat presented in that cycle is ignored.
- Arithmetic: internal CRC register is CRC_W bits. Parameters are truncated to CRC_W bits.
- Reset values: `s_ready` = 1, `crc_valid` = 0, `crc_out` = 0, `crc_match` = 0, `frame_len` = 0. Internal CRC register = INIT.
- Reset asserted mid-frame or mid-HOLD returns the block to the reset state immediately. No partial result is kept.

## Timing
- Throughput: one beat per cycle (DATA_BYTES bytes) while in RUN.
- Latency: `crc_valid` rises on the first edge after the `s_last` beat is accepted, i.e. one cycle.
- Back-to-back frames: at least one bubble cycle after each last beat. With `crc_ready` tied high the block is in HOLD for exactly one cycle.
- `s_ready` and `crc_valid` are decoded from the registered state only; there is no combinational path from inputs.
- Update logic is fully unrolled: 8*DATA_BYTES steps in one cycle, with no pipeline register.

## Structure
- Package `crc_pkg`:
  - state enum `crc_state_t {RUN, HOLD}`.
  - function `crc_step8(crc, byte, poly, reflect)`.
  - defaults for the CRC-32 and CRC-16/CCITT-FALSE parameter sets.
- Sub-module `crc_update`: combinational CRC update for DATA_BYTES bytes with a keep mask. It contains no state and is instantiated once.
- Top `crc_stream`: FSM, CRC register, byte counter and result registers.

## Test plan
- CRC-32 defaults, DATA_BYTES=4, frame "123456789" as three beats:
  - beat 1: 32'h34333231, keep 4'hF.
  - beat 2: 32'h38373635, keep 4'hF.
  - beat 3: 32'h00000039, keep 4'h1, last.
  - Required result: `crc_out` = 32'hCBF43926, `frame_len` = 9, `crc_match` = 0, `crc_valid` one cycle after the last beat.
- The same frame followed by bytes 26 39 F4 CB: `crc_out` = 32'h2144DF1C, `crc_match` = 1, `frame_len` = 13.
- CRC_W=16, POLY=16'h1021, INIT=16'hFFFF, XOR_OUT=0, REFLECT=0, DATA_BYTES=1, "123456789": `crc_out` = 16'h29B1.
- Empty frame: a single beat with keep 0 and last, CRC-32 defaults: `crc_out` = 0, `frame_len` = 0.
- Backpressure and abort:
  - Hold `crc_ready` = 0 for 5 cycles: `s_ready` stays 0 and `crc_out` stays stable throughout.
  - `clear` mid-frame, then the "123456789" frame again: result = 32'hCBF43926.
- `reset_n` pulsed low mid-frame: all outputs return to their reset values asynchronously. The next frame computes correctly from INIT.
